// File: rtl/fractal_sync_mp_rx.sv
// Multi-port rx stage of the fractal synchronization tree.
// Each port samples (optionally), classifies and queues propagate requests;
// a round-robin arbiter merges the port FIFOs into one valid/ready stream.

// Per-port lane: input sample stage, classifier, private FIFO, sticky overflow.
module fractal_sync_mp_rx_port #(
  parameter int         AGGR_W     = 4,
  parameter int         ID_W       = 2,
  parameter int         SRC_W      = 2,
  parameter int         FIFO_DEPTH = 2,
  parameter int         COMB_IN    = 0,
  parameter logic [1:0] TAG        = 2'b11,
  localparam int        CNT_W      = $clog2(FIFO_DEPTH+1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_sync,
  input  logic [AGGR_W-1:0] i_aggr,
  input  logic [ID_W-1:0]   i_id,
  input  logic [SRC_W-1:0]  i_src,
  input  logic              i_pop,
  input  logic              i_err_clr,
  output logic              o_local,
  output logic              o_root,
  output logic              o_empty,
  output logic              o_err,
  output logic [AGGR_W-2:0] o_head_aggr,
  output logic [ID_W-1:0]   o_head_id,
  output logic [SRC_W+1:0]  o_head_src,
  output logic [CNT_W-1:0]  o_cnt
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [AGGR_W-2:0] aggr;
    logic [ID_W-1:0]   id;
    logic [SRC_W+1:0]  src;
  } entry_t;

  logic              w_sync;
  logic [AGGR_W-1:0] w_aggr;
  logic [ID_W-1:0]   w_id;
  logic [SRC_W-1:0]  w_src;

  if (COMB_IN != 0) begin : g_comb
    assign w_sync = i_sync;
    assign w_aggr = i_aggr;
    assign w_id   = i_id;
    assign w_src  = i_src;
  end else begin : g_reg
    logic              r_sync;
    logic [AGGR_W-1:0] r_aggr;
    logic [ID_W-1:0]   r_id;
    logic [SRC_W-1:0]  r_src;
    // Strobe sampled every cycle; payload only captured with a strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_sync <= 1'b0;
        r_aggr <= '0;
        r_id   <= '0;
        r_src  <= '0;
      end else begin
        r_sync <= i_sync;
        if (i_sync) begin
          r_aggr <= i_aggr;
          r_id   <= i_id;
          r_src  <= i_src;
        end
      end
    end
    assign w_sync = r_sync;
    assign w_aggr = r_aggr;
    assign w_id   = r_id;
    assign w_src  = r_src;
  end

  entry_t                         w_new;
  entry_t [FIFO_DEPTH-1:0]        r_mem;
  logic   [PTR_W-1:0]             r_wr, r_rd;
  logic   [CNT_W-1:0]             r_cnt;
  logic                           w_prop, w_full, w_push, w_drop, w_pop;
  logic                           r_err;

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign o_local = w_sync & w_aggr[0];
  assign o_root  = w_sync & (w_aggr == AGGR_W'(1));
  assign w_prop  = w_sync & ~w_aggr[0];
  assign o_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CNT_W'(FIFO_DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  // A full FIFO still takes the entry when its head leaves on the same edge.
  assign w_push  = w_prop & (~w_full | w_pop);
  assign w_drop  = w_prop & w_full & ~w_pop;
  assign w_new   = {w_aggr[AGGR_W-1:1], w_id, w_src, TAG};

  // Circular buffer; on push-while-full the write slot equals the slot being popped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_new;
        r_wr        <= f_inc(r_wr);
      end
      if (w_pop) r_rd <= f_inc(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        r_err <= 1'b0;
    else if (w_drop)    r_err <= 1'b1;
    else if (i_err_clr) r_err <= 1'b0;
  end

  assign o_err = r_err;
  assign {o_head_aggr, o_head_id, o_head_src} = r_mem[r_rd];
  assign o_cnt = r_cnt;
endmodule

// Top: lane array plus round-robin merge.
module fractal_sync_mp_rx #(
  parameter int  N_PORTS    = 2,
  parameter int  AGGR_W     = 4,
  parameter int  ID_W       = 2,
  parameter int  SRC_W      = 2,
  parameter int  FIFO_DEPTH = 2,
  parameter int  COMB_IN    = 0,
  parameter      SD_MASK    = {N_PORTS{2'b11}},
  localparam int PORT_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
  localparam int FILL_W     = $clog2(N_PORTS*FIFO_DEPTH+1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_PORTS-1:0]        req_sync_i,
  input  logic [N_PORTS*AGGR_W-1:0] req_aggr_i,
  input  logic [N_PORTS*ID_W-1:0]   req_id_i,
  input  logic [N_PORTS*SRC_W-1:0]  req_src_i,
  output logic [N_PORTS-1:0]        local_o,
  output logic [N_PORTS-1:0]        root_o,
  output logic [N_PORTS-1:0]        error_overflow_o,
  input  logic                      err_clr_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [AGGR_W-2:0]         req_aggr_o,
  output logic [ID_W-1:0]           req_id_o,
  output logic [SRC_W+1:0]          req_src_o,
  output logic [PORT_W-1:0]         req_port_o,
  output logic [FILL_W-1:0]         fill_o
);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  if (FIFO_DEPTH < 1)              begin : g_chk_depth $error("FIFO_DEPTH must be >= 1"); end
  if (AGGR_W < 2)                  begin : g_chk_aggr  $error("AGGR_W must be >= 2"); end
  if (N_PORTS < 1)                 begin : g_chk_ports $error("N_PORTS must be >= 1"); end
  if ($bits(SD_MASK) != 2*N_PORTS) begin : g_chk_mask  $error("SD_MASK must be 2*N_PORTS bits"); end

  logic [N_PORTS-1:0]             w_empty, w_pop;
  logic [N_PORTS-1:0][AGGR_W-2:0] w_h_aggr;
  logic [N_PORTS-1:0][ID_W-1:0]   w_h_id;
  logic [N_PORTS-1:0][SRC_W+1:0]  w_h_src;
  logic [N_PORTS-1:0][CNT_W-1:0]  w_cnt;
  logic [PORT_W-1:0]              r_ptr, r_lgrant, w_rr, w_grant;
  logic                           r_locked, w_valid, w_hs;
  logic [FILL_W-1:0]              w_fill;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    fractal_sync_mp_rx_port #(
      .AGGR_W(AGGR_W), .ID_W(ID_W), .SRC_W(SRC_W), .FIFO_DEPTH(FIFO_DEPTH),
      .COMB_IN(COMB_IN), .TAG(SD_MASK[2*p +: 2])
    ) u_port (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .i_sync      (req_sync_i[p]),
      .i_aggr      (req_aggr_i[p*AGGR_W +: AGGR_W]),
      .i_id        (req_id_i[p*ID_W +: ID_W]),
      .i_src       (req_src_i[p*SRC_W +: SRC_W]),
      .i_pop       (w_pop[p]),
      .i_err_clr   (err_clr_i),
      .o_local     (local_o[p]),
      .o_root      (root_o[p]),
      .o_empty     (w_empty[p]),
      .o_err       (error_overflow_o[p]),
      .o_head_aggr (w_h_aggr[p]),
      .o_head_id   (w_h_id[p]),
      .o_head_src  (w_h_src[p]),
      .o_cnt       (w_cnt[p])
    );
    assign w_pop[p] = w_hs & (w_grant == PORT_W'(p));
  end

  // First non-empty port at or after the pointer; scanning from the far end
  // lets the nearest one win.
  always_comb begin
    w_rr = r_ptr;
    for (int i = N_PORTS-1; i >= 0; i--) begin
      logic [PORT_W:0] v_sum;
      v_sum = {1'b0, r_ptr} + (PORT_W+1)'(i);
      if (v_sum >= (PORT_W+1)'(N_PORTS)) v_sum = v_sum - (PORT_W+1)'(N_PORTS);
      if (!w_empty[v_sum[PORT_W-1:0]]) w_rr = v_sum[PORT_W-1:0];
    end
  end

  // A stalled grant is frozen so a port filling up later cannot preempt it.
  assign w_grant = r_locked ? r_lgrant : w_rr;
  assign w_valid = ~&w_empty;
  assign w_hs    = w_valid & ready_i;

  // Pointer advances past the served port; lock tracks a presented, unaccepted grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr    <= '0;
      r_lgrant <= '0;
      r_locked <= 1'b0;
    end else begin
      r_locked <= w_valid & ~ready_i;
      r_lgrant <= w_grant;
      if (w_hs) r_ptr <= (w_grant == PORT_W'(N_PORTS-1)) ? '0 : w_grant + 1'b1;
    end
  end

  // Total occupancy across all lanes.
  always_comb begin
    w_fill = '0;
    for (int p = 0; p < N_PORTS; p++) w_fill = w_fill + FILL_W'(w_cnt[p]);
  end

  assign valid_o    = w_valid;
  assign req_aggr_o = w_valid ? w_h_aggr[w_grant] : '0;
  assign req_id_o   = w_valid ? w_h_id[w_grant]   : '0;
  assign req_src_o  = w_valid ? w_h_src[w_grant]  : '0;
  assign req_port_o = w_valid ? w_grant           : '0;
  assign fill_o     = w_fill;
endmodule
